instruction_fetch: RTL and testbench

Instruction-fetch stage feeding the decode stage: it holds the PC, drives a synchronous (1-cycle read latency) instruction memory, and registers the fetched instruction and its PC+4 into the IF/ID pipeline register. A 1-entry skid register absorbs the in-flight memory response when the hazard unit stalls the pipe, so a stall never drops or repeats an instruction. A taken branch from execute redirects the PC and squashes wrong-path fetches.

---
 rtl/instruction_fetch.sv | 111 +++++++++++
 tb/tb_instruction_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC register, synchronous imem interface, IF/ID pipeline register,
// and a one-entry skid buffer that holds the in-flight memory response across stalls.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] instOut,
    output logic [31:0] pc4Out,
    output logic        validOut
);

    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc4_q, fetch_pc4_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic        src_valid;
    logic [31:0] src_inst;
    logic [31:0] src_pc4;

    // Word alignment is forced, so the low target bits carry no information.
    logic unused_target_bits;
    assign unused_target_bits = ^branchTarget[1:0];

    assign pc_plus4 = pc_q + 32'd4;

    // A parked skid entry is older than the response arriving now, so it goes first.
    assign src_valid = skid_valid_q | fetch_valid_q;
    assign src_inst  = skid_valid_q ? skid_inst_q : imemData;
    assign src_pc4   = skid_valid_q ? skid_pc4_q  : fetch_pc4_q;

    always_comb begin
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc4_d   = fetch_pc4_q;
        skid_valid_d  = skid_valid_q;
        skid_inst_d   = skid_inst_q;
        skid_pc4_d    = skid_pc4_q;
        inst_d        = inst_q;
        pc4_d         = pc4_q;
        valid_d       = valid_q;

        if (branchTaken) begin
            pc_d          = {branchTarget[31:2], 2'b00};
            fetch_valid_d = 1'b0;
            skid_valid_d  = 1'b0;
            inst_d        = NOP_INST;
            pc4_d         = 32'd0;
            valid_d       = 1'b0;
        end else if (stall) begin
            if (fetch_valid_q && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_inst_d  = imemData;
                skid_pc4_d   = fetch_pc4_q;
            end
            // The held PC is re-presented; its response next cycle is a duplicate.
            fetch_valid_d = 1'b0;
        end else begin
            valid_d       = src_valid;
            inst_d        = src_valid ? src_inst : NOP_INST;
            pc4_d         = src_valid ? src_pc4 : 32'd0;
            skid_valid_d  = 1'b0;
            fetch_valid_d = 1'b1;
            fetch_pc4_d   = pc_plus4;
            pc_d          = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            fetch_pc4_q   <= 32'd0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= 32'd0;
            skid_pc4_q    <= 32'd0;
            inst_q        <= NOP_INST;
            pc4_q         <= 32'd0;
            valid_q       <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc4_q   <= fetch_pc4_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc4_q    <= skid_pc4_d;
            inst_q        <= inst_d;
            pc4_q         <= pc4_d;
            valid_q       <= valid_d;
        end
    end

    assign imemAddr = pc_q;
    assign instOut  = inst_q;
    assign pc4Out   = pc4_q;
    assign validOut = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations, then random
// stall/branch/reset traffic checked every cycle against an instruction-stream model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] instOut;
    logic [31:0] pc4Out;
    logic        validOut;

    int n_cmp = 0;
    int n_mis = 0;

    instruction_fetch #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .imemAddr    (imemAddr),
        .imemData    (imemData),
        .instOut     (instOut),
        .pc4Out      (pc4Out),
        .validOut    (validOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // Synchronous memory, one cycle read latency.
    always @(posedge clk) imemData <= mem_word(imemAddr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Stream model: outputs walk a sequential address stream; redirect/reset restart it after
    // two bubble cycles; a stall simply freezes everything, including the bubble countdown.
    logic        m_live = 1'b0;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_pc4_known;
    logic [31:0] m_next;
    int          m_pend;

    always @(posedge clk) begin
        if (rst || branchTaken) begin
            m_live      = 1'b1;
            m_valid     = 1'b0;
            m_inst      = 32'd0;
            m_pc4       = 32'd0;
            m_pc4_known = 1'b1;
            m_next      = rst ? 32'd0 : (branchTarget & ~32'd3);
            m_pend      = 1;
        end else if (stall) begin
            m_pend = m_pend;
        end else if (m_pend > 0) begin
            m_valid     = 1'b0;
            m_inst      = 32'd0;
            m_pc4_known = 1'b0;
            m_pend--;
        end else begin
            m_valid     = 1'b1;
            m_inst      = mem_word(m_next);
            m_pc4       = m_next + 32'd4;
            m_pc4_known = 1'b1;
            m_next      = m_next + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_valid", {31'd0, validOut}, {31'd0, m_valid});
            chk("model_inst", instOut, m_inst);
            if (m_pc4_known) chk("model_pc4", pc4Out, m_pc4);
        end
    end

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        rst          = r;
        stall        = s;
        branchTaken  = b;
        branchTarget = t;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] inst,
                              input logic [31:0] pc4);
        chk({name, "_valid"}, {31'd0, validOut}, {31'd0, v});
        chk({name, "_inst"}, instOut, inst);
        chk({name, "_pc4"}, pc4Out, pc4);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'd0;

        // Reset and streaming
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("rst_c0", 0, 32'h0, 32'h0);
        chk("rst_addr", imemAddr, 32'h0);
        step(0, 0, 0, 0);
        chk("c1_valid", {31'd0, validOut}, 32'd0);
        step(0, 0, 0, 0);
        expect_out("c2", 1, 32'h1000_0000, 32'h4);
        step(0, 0, 0, 0);
        expect_out("c3", 1, 32'h1000_0001, 32'h8);
        step(0, 0, 0, 0);
        expect_out("c4", 1, 32'h1000_0002, 32'hC);

        // Three-cycle stall holding the word at 0x8
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            expect_out("stall_hold", 1, 32'h1000_0002, 32'hC);
        end
        step(0, 0, 0, 0);
        expect_out("stall_rel0", 1, 32'h1000_0003, 32'h10);
        step(0, 0, 0, 0);
        expect_out("stall_rel1", 1, 32'h1000_0004, 32'h14);

        // Branch with misaligned target
        step(0, 0, 1, 32'h43);
        expect_out("br_t1", 0, 32'h0, 32'h0);
        step(0, 0, 0, 0);
        chk("br_t2_valid", {31'd0, validOut}, 32'd0);
        chk("br_t2_inst", instOut, 32'h0);
        step(0, 0, 0, 0);
        expect_out("br_t3", 1, 32'h1000_0010, 32'h44);

        // Branch while stalled with the skid occupied
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h100);
        expect_out("brst_t1", 0, 32'h0, 32'h0);
        step(0, 0, 0, 0);
        chk("brst_t2_valid", {31'd0, validOut}, 32'd0);
        step(0, 0, 0, 0);
        expect_out("brst_t3", 1, 32'h1000_0040, 32'h104);
        step(0, 0, 0, 0);
        expect_out("brst_t4", 1, 32'h1000_0041, 32'h108);

        // Address wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_out("wrap0", 1, 32'h4FFF_FFFF, 32'h0);
        step(0, 0, 0, 0);
        expect_out("wrap1", 1, 32'h1000_0000, 32'h4);

        // Reset while the skid holds an entry
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rstst_valid", {31'd0, validOut}, 32'd0);
        chk("rstst_pc4", pc4Out, 32'h0);
        step(0, 0, 0, 0);
        chk("rstst_c1_valid", {31'd0, validOut}, 32'd0);
        step(0, 0, 0, 0);
        expect_out("rstst_c2", 1, 32'h1000_0000, 32'h4);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic        r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 249) == 0);
            b = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = $urandom;
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            step(r, s, b, t);
        end

        step(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
